// File: rtl/disp_ctrl.sv
// Four-digit multiplexed seven-segment display controller with CPU
// register access and frame-synchronous shadow registers.
module disp_ctrl #(
  parameter int DATA_W      = 32,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [7:0]        Disp,
  output logic [3:0]        Disp_sel
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);

  logic [15:0]       val_stg_q, val_stg_d;
  logic [3:0]        dp_stg_q, dp_stg_d;
  logic [3:0]        blk_stg_q, blk_stg_d;
  logic              en_q, en_d;
  logic [15:0]       val_sh_q, val_sh_d;
  logic [3:0]        dp_sh_q, dp_sh_d;
  logic [3:0]        blk_sh_q, blk_sh_d;
  logic              fd_q, fd_d;
  logic [1:0]        idx_q, idx_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [7:0]        disp_q, disp_d;
  logic [3:0]        dsel_q, dsel_d;

  logic wr, rd, tick, bound;
  logic unused_data;

  assign unused_data = ^data_in;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    wr    = sel & we;
    rd    = sel & ~we;
    tick  = en_q && (presc_q == PMAX);
    bound = tick && (idx_q == 2'd3);

    val_stg_d = val_stg_q;
    dp_stg_d  = dp_stg_q;
    blk_stg_d = blk_stg_q;
    en_d      = en_q;
    val_sh_d  = val_sh_q;
    dp_sh_d   = dp_sh_q;
    blk_sh_d  = blk_sh_q;
    fd_d      = fd_q;
    dout_d    = dout_q;

    if (wr) begin
      unique case (addr)
        2'd0: val_stg_d = data_in[15:0];
        2'd1: dp_stg_d  = data_in[3:0];
        2'd2: blk_stg_d = data_in[3:0];
        2'd3: en_d      = data_in[0];
      endcase
    end

    // Shadows track staging while idle, else only at frame wrap
    if (!en_q || bound) begin
      val_sh_d = val_stg_q;
      dp_sh_d  = dp_stg_q;
      blk_sh_d = blk_stg_q;
    end

    presc_d = (en_q && en_d && !tick) ? presc_q + PW'(1) : '0;
    idx_d   = (en_q && en_d) ? idx_q + {1'b0, tick} : 2'd0;

    if (rd && addr == 2'd3) fd_d = 1'b0;
    if (bound)              fd_d = 1'b1;

    if (rd) begin
      unique case (addr)
        2'd0: dout_d = DATA_W'(val_stg_q);
        2'd1: dout_d = DATA_W'(dp_stg_q);
        2'd2: dout_d = DATA_W'(blk_stg_q);
        2'd3: dout_d = DATA_W'({fd_q, idx_q, en_q});
      endcase
    end

    // Outputs follow next state so the digit shows on the edge idx changes
    dsel_d = 4'hF;
    disp_d = 8'hFF;
    if (en_d) begin
      dsel_d = ~(4'b0001 << idx_d);
      if (!blk_sh_d[idx_d])
        disp_d = {~dp_sh_d[idx_d], seg7(val_sh_d[{idx_d, 2'b00} +: 4])};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_stg_q <= '0;
      dp_stg_q  <= '0;
      blk_stg_q <= '0;
      en_q      <= 1'b0;
      val_sh_q  <= '0;
      dp_sh_q   <= '0;
      blk_sh_q  <= '0;
      fd_q      <= 1'b0;
      idx_q     <= '0;
      presc_q   <= '0;
      dout_q    <= '0;
      disp_q    <= 8'hFF;
      dsel_q    <= 4'hF;
    end else begin
      val_stg_q <= val_stg_d;
      dp_stg_q  <= dp_stg_d;
      blk_stg_q <= blk_stg_d;
      en_q      <= en_d;
      val_sh_q  <= val_sh_d;
      dp_sh_q   <= dp_sh_d;
      blk_sh_q  <= blk_sh_d;
      fd_q      <= fd_d;
      idx_q     <= idx_d;
      presc_q   <= presc_d;
      dout_q    <= dout_d;
      disp_q    <= disp_d;
      dsel_q    <= dsel_d;
    end
  end

  assign data_out = dout_q;
  assign Disp     = disp_q;
  assign Disp_sel = dsel_q;

endmodule

// File: tb/tb_disp_ctrl.sv
// Bench for disp_ctrl: directed literal checks plus random register
// traffic compared every cycle against a time-based display model.
module tb_disp_ctrl;

  localparam int DIV = 4;
  localparam int FR  = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst, sel, we;
  logic [1:0]  addr;
  logic [31:0] data_in, data_out;
  logic [7:0]  Disp;
  logic [3:0]  Disp_sel;

  disp_ctrl #(.DATA_W(32), .REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
    .data_in(data_in), .data_out(data_out),
    .Disp(Disp), .Disp_sel(Disp_sel)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 0;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
    7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: m_t counts cycles since the display was enabled, modulo one frame
  bit          m_en, m_fd;
  int          m_t;
  logic [15:0] m_vs, m_vsh;
  logic [3:0]  m_ds, m_dsh, m_bs, m_bsh;
  logic [31:0] m_dout;

  task automatic model_reset();
    m_en = 0; m_fd = 0; m_t = 0;
    m_vs = 0; m_vsh = 0; m_ds = 0; m_dsh = 0; m_bs = 0; m_bsh = 0;
    m_dout = 0;
  endtask

  task automatic model_outs(output logic [7:0] d, output logic [3:0] s);
    int i;
    d = 8'hFF;
    s = 4'hF;
    if (m_en) begin
      i = (m_t / DIV) % 4;
      s = ~(4'b0001 << i);
      if (!m_bsh[i]) d = {~m_dsh[i], seg_tbl[m_vsh[i*4 +: 4]]};
    end
  endtask

  task automatic model_step(input logic s, input logic w,
                            input logic [1:0] a, input logic [31:0] d);
    bit wr, rd, bnd, nen;
    int i;
    logic [1:0] i2;
    wr  = s && w;
    rd  = s && !w;
    i   = m_en ? (m_t / DIV) % 4 : 0;
    i2  = i[1:0];
    bnd = m_en && (m_t % FR == FR - 1);
    if (rd) begin
      case (a)
        2'd0: m_dout = {16'h0, m_vs};
        2'd1: m_dout = {28'h0, m_ds};
        2'd2: m_dout = {28'h0, m_bs};
        default: m_dout = {28'h0, m_fd, i2, m_en};
      endcase
    end
    if (bnd) m_fd = 1;
    else if (rd && a == 2'd3) m_fd = 0;
    if (!m_en || bnd) begin
      m_vsh = m_vs; m_dsh = m_ds; m_bsh = m_bs;
    end
    nen = (wr && a == 2'd3) ? d[0] : m_en;
    m_t = (m_en && nen) ? (m_t + 1) % FR : 0;
    m_en = nen;
    if (wr && a == 2'd0) m_vs = d[15:0];
    if (wr && a == 2'd1) m_ds = d[3:0];
    if (wr && a == 2'd2) m_bs = d[3:0];
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] ed;
    logic [3:0] es;
    if (chk_on) begin
      model_outs(ed, es);
      check("model_disp", {24'h0, Disp}, {24'h0, ed});
      check("model_sel", {28'h0, Disp_sel}, {28'h0, es});
      check("model_dout", data_out, m_dout);
    end
  end

  task automatic step(input logic s, input logic w,
                      input logic [1:0] a, input logic [31:0] d);
    sel = s; we = w; addr = a; data_in = d;
    @(posedge clk);
    model_step(s, w, a, d);
    #1;
    sel = 0; we = 0;
  endtask

  task automatic idle();
    step(0, 0, 2'd0, 32'h0);
  endtask

  task automatic wait_t(input int t);
    for (int k = 0; k < 2 * FR && m_t != t; k++) idle();
  endtask

  logic [3:0] exp_s [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [7:0] exp_d [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};

  initial begin
    rst = 0; sel = 0; we = 0; addr = 0; data_in = 0;
    model_reset();
    #3 rst = 1;
    #1;
    check("rst_disp", {24'h0, Disp}, 32'hFF);
    check("rst_sel", {28'h0, Disp_sel}, 32'hF);
    check("rst_dout", data_out, 32'h0);
    #8 rst = 0;
    chk_on = 1;

    step(1, 1, 2'd0, 32'hFFFF_1234);
    step(1, 1, 2'd3, 32'h1);
    for (int c = 0; c < FR; c++) begin
      check("frame_sel", {28'h0, Disp_sel}, {28'h0, exp_s[c / DIV]});
      check("frame_disp", {24'h0, Disp}, {24'h0, exp_d[c / DIV]});
      idle();
    end
    step(1, 0, 2'd3, 32'h0);
    check("fd_set", data_out, 32'h9);
    step(1, 0, 2'd3, 32'h0);
    check("fd_clr", data_out, 32'h1);

    wait_t(5);
    step(1, 1, 2'd0, 32'h0000_ABCD);
    check("mid_frame_old", {24'h0, Disp}, 32'hB0);
    wait_t(FR - 1);
    idle();
    check("new_frame_disp", {24'h0, Disp}, 32'hA1);
    check("new_frame_sel", {28'h0, Disp_sel}, 32'hE);

    step(1, 0, 2'd3, 32'h0);
    check("fd_pre", {31'h0, data_out[3]}, 32'h1);
    wait_t(FR - 1);
    step(1, 0, 2'd3, 32'h0);
    check("fd_coincide", {31'h0, data_out[3]}, 32'h0);
    step(1, 0, 2'd3, 32'h0);
    check("fd_after", {31'h0, data_out[3]}, 32'h1);

    step(1, 1, 2'd1, 32'h5);
    step(1, 1, 2'd2, 32'h8);
    wait_t(FR - 1);
    idle();
    for (int c = 0; c < FR; c++) begin
      if (c == 0)
        check("dp_d0", {24'h0, Disp}, 32'h21);
      if (c == 2 * DIV)
        check("dp_d2", {24'h0, Disp}, 32'h03);
      if (c == 3 * DIV) begin
        check("blank_d3", {24'h0, Disp}, 32'hFF);
        check("blank_sel", {28'h0, Disp_sel}, 32'h7);
      end
      idle();
    end

    wait_t(6);
    step(1, 1, 2'd3, 32'h0);
    check("off_disp", {24'h0, Disp}, 32'hFF);
    check("off_sel", {28'h0, Disp_sel}, 32'hF);
    step(1, 0, 2'd3, 32'h0);
    check("off_stat", {29'h0, data_out[2:0]}, 32'h0);

    step(1, 1, 2'd3, 32'h1);
    repeat (6) idle();
    #2 chk_on = 0;
    rst = 1;
    #1;
    check("mrst_disp", {24'h0, Disp}, 32'hFF);
    check("mrst_sel", {28'h0, Disp_sel}, 32'hF);
    check("mrst_dout", data_out, 32'h0);
    model_reset();
    @(posedge clk);
    #2 rst = 0;
    chk_on = 1;
    step(1, 0, 2'd3, 32'h0);
    check("mrst_stat", data_out, 32'h0);
    repeat (5) idle();
    check("mrst_blank", {24'h0, Disp}, 32'hFF);

    for (int n = 0; n < 3000; n++) begin
      logic [1:0]  a;
      logic [31:0] d;
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == 2'd3) d[0] = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 5) == 0)
        step(1, 1'($urandom_range(0, 1)), a, d);
      else
        idle();
    end

    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
